// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I/RV64I decode stage between fetch and execute.
// Produces the execute control word behind a valid/ready output register and
// adds a load-use interlock, flush, and illegal/misaligned detection.
module rv_decode_stage #(
   parameter int XLEN     = 32,
   parameter int LOAD_LAT = 1,
   localparam int NB      = XLEN / 8,
   localparam int OW      = $clog2(NB)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   instr,
   input  logic [OW-1:0] addr_off,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          mw,
   output logic          rw,
   output logic          md,
   output logic          mb,
   output logic          mp,
   output logic [3:0]    fs,
   output logic [4:0]    rd,
   output logic [4:0]    rs1,
   output logic [4:0]    rs2,
   output logic [6:0]    opcode,
   output logic [2:0]    funct3,
   output logic [NB-1:0] strb,
   output logic          illegal,
   output logic          misaligned
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic       IS_RV64   = (XLEN == 64);

   typedef struct packed {
      logic          mw;
      logic          rw;
      logic          md;
      logic          mb;
      logic          mp;
      logic [3:0]    fs;
      logic [4:0]    rd;
      logic [4:0]    rs1;
      logic [4:0]    rs2;
      logic [6:0]    opcode;
      logic [2:0]    funct3;
      logic [NB-1:0] strb;
      logic          illegal;
      logic          misaligned;
   } ctl_t;

   // Byte lanes touched by an access of size 1<<sz starting at lane off.
   function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz, input logic [OW-1:0] off);
      logic [NB-1:0] base;
      case (sz)
         2'b00:   base = NB'(1'b1);
         2'b01:   base = NB'(2'b11);
         2'b10:   base = NB'(4'hF);
         2'b11:   base = '1;
         default: base = '0;
      endcase
      return base << off;
   endfunction

   // True when the low address bits are not a multiple of the access size.
   function automatic logic access_misaligned(input logic [1:0] sz, input logic [OW-1:0] off);
      logic res;
      case (sz)
         2'b00:   res = 1'b0;
         2'b01:   res = off[0];
         2'b10:   res = |off[1:0];
         2'b11:   res = |off;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Instruction fields
   logic [6:0] op_s;
   logic [2:0] f3_s;
   logic       f7b_s;
   logic [4:0] rd_f_s, rs1_f_s, rs2_f_s;
   logic       unused_imm_bits;

   assign op_s    = instr[6:0];
   assign f3_s    = instr[14:12];
   assign f7b_s   = instr[30];
   assign rd_f_s  = instr[11:7];
   assign rs1_f_s = instr[19:15];
   assign rs2_f_s = instr[24:20];
   assign unused_imm_bits = ^{instr[31], instr[29:25]};

   // Raw decode results before illegal/misaligned suppression
   logic       r_mw, r_rw, r_md, r_mb, r_mp;
   logic [3:0] r_fs;
   logic       use_rs1_s, use_rs2_s, use_rd_s;
   logic       is_load_s, mem_op_s, mem_bad_s, op_bad_s;
   logic       ill_s, mis_s;
   ctl_t       dec_word_s;

   // Opcode decode into raw control bits and register-usage flags
   always_comb begin
      r_mw      = 1'b0;
      r_rw      = 1'b0;
      r_md      = 1'b0;
      r_mb      = 1'b0;
      r_mp      = 1'b0;
      r_fs      = 4'b0000;
      use_rs1_s = 1'b0;
      use_rs2_s = 1'b0;
      use_rd_s  = 1'b0;
      is_load_s = 1'b0;
      mem_op_s  = 1'b0;
      mem_bad_s = 1'b0;
      op_bad_s  = 1'b0;
      case (op_s)
         OP_R: begin
            r_rw = 1'b1; r_fs = {f7b_s, f3_s};
            use_rs1_s = 1'b1; use_rs2_s = 1'b1; use_rd_s = 1'b1;
         end
         OP_I: begin
            r_rw = 1'b1; r_mb = 1'b1;
            // Only the shifts carry a funct7 bit; for the rest it is immediate data.
            r_fs = ((f3_s == 3'b001) || (f3_s == 3'b101)) ? {f7b_s, f3_s} : {1'b0, f3_s};
            use_rs1_s = 1'b1; use_rd_s = 1'b1;
         end
         OP_JALR: begin
            r_rw = 1'b1; r_mb = 1'b1; r_fs = {1'b0, f3_s};
            use_rs1_s = 1'b1; use_rd_s = 1'b1;
         end
         OP_JAL: begin
            r_rw = 1'b1; r_mb = 1'b1; use_rd_s = 1'b1;
         end
         OP_LUI: begin
            r_rw = 1'b1; r_mb = 1'b1; use_rd_s = 1'b1;
         end
         OP_AUIPC: begin
            r_rw = 1'b1; r_mb = 1'b1; r_mp = 1'b1; use_rd_s = 1'b1;
         end
         OP_BRANCH: begin
            use_rs1_s = 1'b1; use_rs2_s = 1'b1;
            case (f3_s)
               3'b000, 3'b001, 3'b100, 3'b101: r_fs = 4'b1000;
               3'b110, 3'b111:                 r_fs = 4'b0011;
               default:                        op_bad_s = 1'b1;
            endcase
         end
         OP_LOAD: begin
            r_md = 1'b1; r_mb = 1'b1; r_rw = 1'b1;
            use_rs1_s = 1'b1; use_rd_s = 1'b1;
            is_load_s = 1'b1; mem_op_s = 1'b1;
            // LD and LWU exist only on RV64; f3 111 is never a load.
            mem_bad_s = (f3_s == 3'b111) ||
                        (!IS_RV64 && ((f3_s == 3'b011) || (f3_s == 3'b110)));
         end
         OP_STORE: begin
            r_mw = 1'b1; r_mb = 1'b1;
            use_rs1_s = 1'b1; use_rs2_s = 1'b1;
            mem_op_s = 1'b1;
            mem_bad_s = f3_s[2] || (!IS_RV64 && (f3_s[1:0] == 2'b11));
         end
         default: op_bad_s = 1'b1;
      endcase
   end

   assign ill_s = op_bad_s | (mem_op_s & mem_bad_s);
   assign mis_s = mem_op_s & ~mem_bad_s & access_misaligned(f3_s[1:0], addr_off);

   // Final control word with illegal and misaligned suppression applied
   always_comb begin
      dec_word_s        = '0;
      dec_word_s.opcode = op_s;
      dec_word_s.funct3 = f3_s;
      if (ill_s) begin
         dec_word_s.illegal = 1'b1;
      end else begin
         dec_word_s.mw         = r_mw & ~mis_s;
         dec_word_s.rw         = r_rw & ~mis_s;
         dec_word_s.md         = r_md;
         dec_word_s.mb         = r_mb;
         dec_word_s.mp         = r_mp;
         dec_word_s.fs         = r_fs;
         dec_word_s.rd         = use_rd_s  ? rd_f_s  : 5'd0;
         dec_word_s.rs1        = use_rs1_s ? rs1_f_s : 5'd0;
         dec_word_s.rs2        = use_rs2_s ? rs2_f_s : 5'd0;
         dec_word_s.strb       = (mem_op_s && !mis_s) ? lane_mask(f3_s[1:0], addr_off) : '0;
         dec_word_s.misaligned = mis_s;
      end
   end

   // Pipeline and interlock state
   ctl_t       ctl_q, ctl_d;
   logic       out_valid_q, out_valid_d;
   logic [1:0] cnt_q, cnt_d;
   logic [4:0] ld_rd_q, ld_rd_d;
   logic       hazard_s, in_ready_s, accept_s, arm_s;

   assign hazard_s = (cnt_q != 2'd0) && in_valid && !ill_s &&
                     ((use_rs1_s && (rs1_f_s == ld_rd_q)) ||
                      (use_rs2_s && (rs2_f_s == ld_rd_q)));
   assign in_ready_s = !hazard_s && !flush && (!out_valid_q || out_ready);
   assign accept_s   = in_valid && in_ready_s;
   assign arm_s      = is_load_s && !ill_s && (rd_f_s != 5'd0) && (LOAD_LAT != 0);

   // Next-state for the output register, valid flag and load-use counter
   always_comb begin
      ctl_d       = ctl_q;
      out_valid_d = out_valid_q;
      cnt_d       = (cnt_q != 2'd0) ? (cnt_q - 2'd1) : 2'd0;
      ld_rd_d     = ld_rd_q;
      if (flush) begin
         out_valid_d = 1'b0;
         cnt_d       = 2'd0;
         ld_rd_d     = 5'd0;
      end else if (accept_s) begin
         ctl_d       = dec_word_s;
         out_valid_d = 1'b1;
         if (arm_s) begin
            // A newly accepted load restarts the window even if one is counting.
            cnt_d   = 2'(LOAD_LAT);
            ld_rd_d = rd_f_s;
         end else begin
            ld_rd_d = ld_rd_q;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl_q       <= '0;
         out_valid_q <= 1'b0;
         cnt_q       <= 2'd0;
         ld_rd_q     <= 5'd0;
      end else begin
         ctl_q       <= ctl_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
         ld_rd_q     <= ld_rd_d;
      end
   end

   assign in_ready   = in_ready_s;
   assign out_valid  = out_valid_q;
   assign mw         = ctl_q.mw;
   assign rw         = ctl_q.rw;
   assign md         = ctl_q.md;
   assign mb         = ctl_q.mb;
   assign mp         = ctl_q.mp;
   assign fs         = ctl_q.fs;
   assign rd         = ctl_q.rd;
   assign rs1        = ctl_q.rs1;
   assign rs2        = ctl_q.rs2;
   assign opcode     = ctl_q.opcode;
   assign funct3     = ctl_q.funct3;
   assign strb       = ctl_q.strb;
   assign illegal    = ctl_q.illegal;
   assign misaligned = ctl_q.misaligned;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: a scoreboard queue holds expected control
// words pushed on accept and compared while the word is presented downstream.
module tb_rv_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid_a, in_valid_b, in_valid_c;
   logic [31:0] instr;
   logic [1:0]  addr_off;
   logic [2:0]  addr_off_c;
   logic        flush, out_ready;

   logic        in_ready_a, out_valid_a, mw_a, rw_a, md_a, mb_a, mp_a, ill_a, mis_a;
   logic [3:0]  fs_a, strb_a;
   logic [4:0]  rd_a, rs1_a, rs2_a;
   logic [6:0]  op_a;
   logic [2:0]  f3_a;

   logic        in_ready_b, out_valid_b, mw_b, rw_b, md_b, mb_b, mp_b, ill_b, mis_b;
   logic [3:0]  fs_b, strb_b;
   logic [4:0]  rd_b, rs1_b, rs2_b;
   logic [6:0]  op_b;
   logic [2:0]  f3_b;

   logic        in_ready_c, out_valid_c, mw_c, rw_c, md_c, mb_c, mp_c, ill_c, mis_c;
   logic [3:0]  fs_c;
   logic [7:0]  strb_c;
   logic [4:0]  rd_c, rs1_c, rs2_c;
   logic [6:0]  op_c;
   logic [2:0]  f3_c;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [39:0] sb_q[$];
   logic [39:0] exp_nxt;
   logic [39:0] obs_a;

   assign obs_a = {mw_a, rw_a, md_a, mb_a, mp_a, fs_a, rd_a, rs1_a, rs2_a, op_a, f3_a, strb_a, ill_a, mis_a};

   always #5 clk = ~clk;

   rv_decode_stage #(.XLEN(32), .LOAD_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .instr(instr),
      .addr_off(addr_off), .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
      .mw(mw_a), .rw(rw_a), .md(md_a), .mb(mb_a), .mp(mp_a), .fs(fs_a), .rd(rd_a),
      .rs1(rs1_a), .rs2(rs2_a), .opcode(op_a), .funct3(f3_a), .strb(strb_a),
      .illegal(ill_a), .misaligned(mis_a));

   rv_decode_stage #(.XLEN(32), .LOAD_LAT(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .instr(instr),
      .addr_off(addr_off), .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
      .mw(mw_b), .rw(rw_b), .md(md_b), .mb(mb_b), .mp(mp_b), .fs(fs_b), .rd(rd_b),
      .rs1(rs1_b), .rs2(rs2_b), .opcode(op_b), .funct3(f3_b), .strb(strb_b),
      .illegal(ill_b), .misaligned(mis_b));

   rv_decode_stage #(.XLEN(64), .LOAD_LAT(1)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c), .instr(instr),
      .addr_off(addr_off_c), .flush(flush), .out_valid(out_valid_c), .out_ready(out_ready),
      .mw(mw_c), .rw(rw_c), .md(md_c), .mb(mb_c), .mp(mp_c), .fs(fs_c), .rd(rd_c),
      .rs1(rs1_c), .rs2(rs2_c), .opcode(op_c), .funct3(f3_c), .strb(strb_c),
      .illegal(ill_c), .misaligned(mis_c));

   function automatic logic [39:0] mk(input logic mw, rw, md, mb, mp, input logic [3:0] fs,
                                      input logic [4:0] rd, rs1, rs2, input logic [6:0] op,
                                      input logic [2:0] f3, input logic [3:0] strb,
                                      input logic ill, mis);
      return {mw, rw, md, mb, mp, fs, rd, rs1, rs2, op, f3, strb, ill, mis};
   endfunction

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock: check handshake and presented word at negedge, then advance.
   task automatic step(input logic exp_rdy, input logic exp_ov, input int exp_rdy_b);
      @(negedge clk);
      chk("in_ready", 40'(in_ready_a), 40'(exp_rdy));
      chk("out_valid", 40'(out_valid_a), 40'(exp_ov));
      if (out_valid_a === 1'b1 && sb_q.size() != 0) begin
         chk("word", obs_a, sb_q[0]);
         if (out_ready) void'(sb_q.pop_front());
      end
      if (exp_rdy_b >= 0) chk("in_ready_b", 40'(in_ready_b), 40'(exp_rdy_b));
      if (in_valid_a && in_ready_a) sb_q.push_back(exp_nxt);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [1:0] off, input logic [39:0] e);
      instr = ins; addr_off = off; exp_nxt = e;
   endtask

   localparam logic [31:0] I_ADD3  = 32'h002081B3; // add  x3,x1,x2
   localparam logic [31:0] I_ADDI4 = 32'h00518213; // addi x4,x3,5
   localparam logic [31:0] I_LW5   = 32'h0000A283; // lw   x5,0(x1)
   localparam logic [31:0] I_ADD6  = 32'h00228333; // add  x6,x5,x2
   localparam logic [31:0] I_LW0   = 32'h0000A003; // lw   x0,0(x1)
   localparam logic [31:0] I_ADD60 = 32'h00200333; // add  x6,x0,x2
   localparam logic [31:0] I_SB    = 32'h00208023; // sb   x2,0(x1)
   localparam logic [31:0] I_SH    = 32'h00209023; // sh   x2,0(x1)
   localparam logic [31:0] I_SD    = 32'h0020B023; // sd   x2,0(x1)
   localparam logic [31:0] I_BAD   = 32'h0000007F;
   localparam logic [31:0] I_BR010 = 32'h0020A063;
   localparam logic [31:0] I_BLTU  = 32'h0020E063; // bltu x1,x2

   initial begin
      rst = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
      instr = 32'h0; addr_off = 2'd0; addr_off_c = 3'd0; flush = 1'b0; out_ready = 1'b1;
      exp_nxt = 40'h0;
      #2;
      chk("rst_out_valid", 40'(out_valid_a), 40'h0);
      chk("rst_word", obs_a, 40'h0);
      chk("rst_out_valid_b", 40'(out_valid_b), 40'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Back-to-back independent ALU ops, then load-use with LOAD_LAT=1
      in_valid_a = 1'b1;
      drive(I_ADD3, 2'd0, mk(0,1,0,0,0,4'h0,5'd3,5'd1,5'd2,7'h33,3'd0,4'h0,0,0));  step(1'b1, 1'b0, -1);
      drive(I_ADDI4, 2'd0, mk(0,1,0,1,0,4'h0,5'd4,5'd3,5'd0,7'h13,3'd0,4'h0,0,0)); step(1'b1, 1'b1, -1);
      drive(I_LW5, 2'd0, mk(0,1,1,1,0,4'h0,5'd5,5'd1,5'd0,7'h03,3'd2,4'hF,0,0));   step(1'b1, 1'b1, -1);
      drive(I_ADD6, 2'd0, mk(0,1,0,0,0,4'h0,5'd6,5'd5,5'd2,7'h33,3'd0,4'h0,0,0));  step(1'b0, 1'b1, -1);
      step(1'b1, 1'b0, -1);
      // Load to x0 never stalls its dependent
      drive(I_LW0, 2'd0, mk(0,1,1,1,0,4'h0,5'd0,5'd1,5'd0,7'h03,3'd2,4'hF,0,0));   step(1'b1, 1'b1, -1);
      drive(I_ADD60, 2'd0, mk(0,1,0,0,0,4'h0,5'd6,5'd0,5'd2,7'h33,3'd0,4'h0,0,0)); step(1'b1, 1'b1, -1);
      // Stores: strobes, misalignment, RV32 sd illegal (RV64 instance checks strobes)
      drive(I_SB, 2'd3, mk(1,0,0,1,0,4'h0,5'd0,5'd1,5'd2,7'h23,3'd0,4'h8,0,0));    step(1'b1, 1'b1, -1);
      drive(I_SH, 2'd2, mk(1,0,0,1,0,4'h0,5'd0,5'd1,5'd2,7'h23,3'd1,4'hC,0,0));    step(1'b1, 1'b1, -1);
      drive(I_SH, 2'd1, mk(0,0,0,1,0,4'h0,5'd0,5'd1,5'd2,7'h23,3'd1,4'h0,0,1));    step(1'b1, 1'b1, -1);
      drive(I_SD, 2'd0, mk(0,0,0,0,0,4'h0,5'd0,5'd0,5'd0,7'h23,3'd3,4'h0,1,0));
      in_valid_c = 1'b1; addr_off_c = 3'd0;
      step(1'b1, 1'b1, -1);
      in_valid_c = 1'b0;
      chk("rv64_sd_strb", 40'(strb_c), 40'hFF);
      chk("rv64_sd_valid", 40'(out_valid_c), 40'h1);
      chk("rv64_sd_illegal", 40'(ill_c), 40'h0);
      // Illegal opcode, illegal branch funct3, bltu
      drive(I_BAD, 2'd0, mk(0,0,0,0,0,4'h0,5'd0,5'd0,5'd0,7'h7F,3'd0,4'h0,1,0));   step(1'b1, 1'b1, -1);
      drive(I_BR010, 2'd0, mk(0,0,0,0,0,4'h0,5'd0,5'd0,5'd0,7'h63,3'd2,4'h0,1,0)); step(1'b1, 1'b1, -1);
      drive(I_BLTU, 2'd0, mk(0,0,0,0,0,4'h3,5'd0,5'd1,5'd2,7'h63,3'd6,4'h0,0,0));  step(1'b1, 1'b1, -1);

      // Downstream stall: held word stays stable, in_ready low
      out_ready = 1'b0;
      drive(I_ADD3, 2'd0, mk(0,1,0,0,0,4'h0,5'd3,5'd1,5'd2,7'h33,3'd0,4'h0,0,0));
      step(1'b0, 1'b1, -1); step(1'b0, 1'b1, -1); step(1'b0, 1'b1, -1);
      out_ready = 1'b1;
      step(1'b1, 1'b1, -1);
      in_valid_a = 1'b0;
      step(1'b1, 1'b1, -1);
      step(1'b1, 1'b0, -1);

      // LOAD_LAT=2 instance: two stall cycles for the dependent add
      in_valid_b = 1'b1;
      drive(I_LW5, 2'd0, 40'h0);  step(1'b1, 1'b0, 1);
      drive(I_ADD6, 2'd0, 40'h0); step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 1);

      // Flush while a stall is pending clears the interlock in both instances
      in_valid_a = 1'b1;
      drive(I_LW5, 2'd0, mk(0,1,1,1,0,4'h0,5'd5,5'd1,5'd0,7'h03,3'd2,4'hF,0,0));   step(1'b1, 1'b0, 1);
      drive(I_ADD6, 2'd0, mk(0,1,0,0,0,4'h0,5'd6,5'd5,5'd2,7'h33,3'd0,4'h0,0,0));
      flush = 1'b1;
      step(1'b0, 1'b1, 0);
      flush = 1'b0;
      step(1'b1, 1'b0, 1);
      in_valid_a = 1'b0; in_valid_b = 1'b0;
      step(1'b1, 1'b1, -1);

      // Asynchronous reset in the middle of a load-use stall
      in_valid_a = 1'b1;
      drive(I_LW5, 2'd0, mk(0,1,1,1,0,4'h0,5'd5,5'd1,5'd0,7'h03,3'd2,4'hF,0,0));   step(1'b1, 1'b0, -1);
      drive(I_ADD6, 2'd0, mk(0,1,0,0,0,4'h0,5'd6,5'd5,5'd2,7'h33,3'd0,4'h0,0,0));
      @(negedge clk);
      chk("stall_in_ready", 40'(in_ready_a), 40'h0);
      chk("stall_out_valid", 40'(out_valid_a), 40'h1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 40'(out_valid_a), 40'h0);
      chk("midrst_word", obs_a, 40'h0);
      sb_q.delete();
      #1 rst = 1'b0;
      #1;
      chk("postrst_in_ready", 40'(in_ready_a), 40'h1);
      sb_q.push_back(exp_nxt);
      @(posedge clk); #1;
      in_valid_a = 1'b0;
      step(1'b1, 1'b1, -1);
      step(1'b1, 1'b0, -1);

      chk("scoreboard_empty", 40'(sb_q.size()), 40'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Registered, parametrised RV32I/RV64I instruction-decode pipeline stage producing the control word (MW, RW, MD, MB, MP, FS, RD, RS1, RS2, STRB) for the execute stage. It sits between fetch and execute and uses valid/ready handshakes on both sides. It adds behaviour the single-cycle decoder lacks: an output pipeline register, a load-use interlock with configurable bubble count, flush, illegal-instruction detection, and misaligned-access detection.

## Interface
- XLEN, 32: datapath width, 32 or 64; NB = XLEN/8 byte lanes; OW = $clog2(NB).
- LOAD_LAT, 1: bubbles required between a load and a dependent instruction, 0–3; 0 disables the interlock.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- instr  in  32  instruction word.
- addr_off  in  OW  low bits of the effective memory address for loads and stores.
- flush  in  1  discard the held and incoming instruction, and clear the interlock.
- out_valid  out  1  control word valid.
- out_ready  in  1  execute consumes the control word.
- mw, rw, md, mb, mp  out  1 each  memory write, register write, memory-to-register select, immediate-B select, PC-operand select.
- fs  out  4  ALU function select.
- rd, rs1, rs2  out  5 each  register indices.
- opcode  out  7; funct3  out  3  raw fields, passed through.
- strb  out  NB  byte-lane strobe.
- illegal  out  1  unsupported opcode or funct3.
- misaligned  out  1  load or store not aligned to its access size.

## Operation
- Decode (combinational, registered on accept):
  - R (0110011): fs={f7[5],f3}; rw=1; rs1, rs2, rd used.
  - I-ALU (0010011): mb=rw=1; fs={f7[5],f3} for f3 001/101, else {0,f3}.
  - JALR (1100111): fs={0,f3}; mb=rw=1; rs2=0.
  - JAL (1101111): fs=0; mb=rw=1; rs2=0.
  - LUI (0110111): mb=rw=1; rs1=rs2=0.
  - AUIPC (0010111): as LUI, plus mp=1.
  - Branch (1100011): rw=0; rd=0; fs=1000 for f3 000/001/100/101; fs=0011 for f3 110/111; f3 010/011 is illegal.
  - Load (0000011): md=mb=rw=1; rs2=0.
  - Store (0100011): mw=mb=1; rd=0; rs2 used.
- Strobes (load and store):
  - byte (f3 x00): 1<<addr_off.
  - half (x01): 3<<addr_off.
  - word (x10, LWU 110): 4'hF<<addr_off.
  - double (011): all ones. Valid only when XLEN=64; when XLEN=32, f3 011 and 110 are illegal.
  - strb=0 for all other opcodes.
- Misaligned: half with addr_off[0]≠0; word with addr_off[1:0]≠0; double with addr_off≠0. On misalignment: misaligned=1, mw=rw=0, strb=0.
- Illegal (any other opcode or bad funct3): illegal=1, all of mw/rw/md/mb/mp=0, strb=0, fs=0.
- Field index usage: rs1 is used by R, I-ALU, JALR, load, store, branch. rs2 is used by R, store, branch.
- Interlock:
  - When a load with rd≠0 is accepted: ld_rd←rd, cnt←LOAD_LAT.
  - cnt decrements by 1 each clock while nonzero.
  - hazard = cnt≠0 ∧ in_valid ∧ (a used rs1 or rs2 equals ld_rd).
- Handshake:
  - in_ready = ¬hazard ∧ ¬flush ∧ (¬out_valid ∨ out_ready).
  - Accept = in_valid ∧ in_ready: the output register loads the decoded word and out_valid←1.
  - If out_ready ∧ ¬accept: out_valid←0 (a bubble during hazard).
- Flush has priority over everything: out_valid←0, cnt←0, ld_rd←0, and no accept that cycle.

## Timing
- Reset (asynchronous): out_valid=0, all control outputs and fields 0, illegal=misaligned=0, cnt=0, ld_rd=0. in_ready follows its equation after release.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle with no hazard.
- While out_valid=1 ∧ out_ready=0, outputs are stable.
- Dependent instruction immediately behind a load: exactly LOAD_LAT cycles with in_ready=0, then accepted.
- A load accepted in the same cycle cnt is decrementing reloads cnt to LOAD_LAT; the load wins.
- A load to x0 never arms the interlock.
- A reset asserted mid-stall clears the stall immediately.

## Test plan
- Back-to-back `add x3,x1,x2` then `addi x4,x3,5` with out_ready=1 → outputs on consecutive cycles; fs=0000 rw=1, then fs=0000 mb=1; in_ready never drops.
- `lw x5,0(x1)` then `add x6,x5,x2`, LOAD_LAT=1 → in_ready=0 for 1 cycle, one bubble (out_valid=0), then add issues. With LOAD_LAT=2 → 2 bubbles. With the dependent on x0 → no stall.
- `sb` with addr_off=3 → strb=1000. `sh` with addr_off=2 → strb=1100. `sh` with addr_off=1 → misaligned=1, mw=0, strb=0. XLEN=64 `sd` with addr_off=0 → strb=8'hFF.
- Opcode 1111111, then branch f3=010 → illegal=1, mw=rw=0. `bltu` → fs=0011 rw=0 rd=0.
- out_ready held low 3 cycles with in_valid=1 → outputs stable and in_ready=0 throughout. flush asserted while a stall is pending → out_valid=0 and cnt=0 next cycle, and the dependent instruction is accepted the following cycle.
- rst pulsed asynchronously mid-stall → all outputs 0 immediately, in_ready=1 after release.
